gnn_buffer_read_arbiter: RTL and testbench
==========================================

Name: gnn_buffer_read_arbiter

Overview:
- Shares the single on-chip feature-buffer read port (address in, data back in order) between NUM_REQ requesters, e.g. the save unit and the compute engine.
- Arbitrates round-robin, with a bounded burst hold so streaming requesters keep back-to-back throughput.
- Registers the granted address onto the buffer port.
- Tracks outstanding reads in an in-order ID FIFO so each returned data beat is flagged to the requester that issued it.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
ADDR_WIDTH, 11, buffer address width
DATA_WIDTH, 512, buffer data width
ID_FIFO_DEPTH, 8, max outstanding reads (power of 2)
MAX_HOLD, 16, max consecutive grants to one requester while another is waiting

Ports:
aclk  in  1  clock
areset  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i = [i*ADDR_WIDTH +: ADDR_WIDTH]
req_ready  out  NUM_REQ  one-hot grant; request i accepted when req_valid[i] && req_ready[i]
rsp_valid  out  NUM_REQ  one-hot; data on rsp_data belongs to requester i
rsp_data  out  DATA_WIDTH  returned data, broadcast to all requesters
buf_addr_valid  out  1  read strobe to buffer
buf_addr  out  ADDR_WIDTH  read address to buffer
buf_data_valid  in  1  buffer read data valid (in order, latency ≥1)
buf_data  in  DATA_WIDTH  buffer read data
outstanding  out  $clog2(ID_FIFO_DEPTH)+1  reads issued but not yet returned
err_unexpected  out  1  sticky; data returned with no read outstanding

Behaviour:
- Reset (areset high at posedge):
  - clear grant pointer, hold counter, ID FIFO and error flag.
  - all outputs 0; buf_addr = 0.
  - reset mid-operation discards outstanding IDs; data beats arriving afterwards set err_unexpected.
- Arbitration (combinational, each cycle):
  - stalled = ID FIFO full (outstanding == ID_FIFO_DEPTH), unless buf_data_valid is high this cycle (pop frees a slot, so same-cycle push is allowed).
  - If stalled: req_ready = 0.
  - Otherwise, if the last-granted requester L still has req_valid and hold_cnt < MAX_HOLD: grant L again.
  - Otherwise: grant the first valid requester scanning from ptr = (L+1) mod NUM_REQ upward.
  - req_ready may only be high for a requester with req_valid high; at most one bit set.
- Grant update (registered):
  - On grant to the same requester as L: hold_cnt++, saturating at MAX_HOLD.
  - On grant to a different requester: L = new, hold_cnt = 1.
  - If no other requester is valid, hold_cnt does not force a switch; the sole requester is granted every cycle.
- Issue:
  - On grant g, next cycle buf_addr_valid = 1 and buf_addr = req_addr slice g.
  - Otherwise buf_addr_valid = 0 and buf_addr holds its value.
  - Request-to-strobe latency is 1 cycle; throughput is 1 read/cycle.
- ID FIFO:
  - Push the granted ID in the grant cycle; pop on buf_data_valid.
  - Simultaneous push and pop leaves outstanding unchanged.
- Response (registered):
  - On buf_data_valid with FIFO non-empty: next cycle rsp_valid = onehot(head ID) and rsp_data = buf_data.
  - On buf_data_valid with FIFO empty: rsp_valid = 0, err_unexpected set; no pop, count unchanged.
  - rsp_data holds its value when rsp_valid = 0.
- Pointer and count arithmetic:
  - ptr wraps modulo NUM_REQ.
  - FIFO pointers wrap modulo ID_FIFO_DEPTH.
  - outstanding never exceeds ID_FIFO_DEPTH and never underflows.

Test Plan:
- Single requester 0 streams addr 0x010..0x01F, buffer latency 2 → 16 strobes on consecutive cycles; rsp_valid = 01 for 16 beats, data in order; req_ready never drops; outstanding peaks at 3.
- Both requesters continuously valid, MAX_HOLD = 4 → grant pattern 0,0,0,0,1,1,1,1,0,… with 4-grant runs; data routed to the matching rsp_valid bit in issue order.
- Buffer data withheld, requester 1 valid → exactly 8 grants, then req_ready = 0 and outstanding = 8. One data beat returns → one new grant in that same cycle; outstanding stays 8.
- req_valid[0] and req_valid[1] rise together after reset → requester 0 granted first; after requester 0 drops, requester 1 granted the next cycle.
- buf_data_valid pulsed with nothing outstanding → err_unexpected = 1 and stays 1; rsp_valid stays 0; outstanding stays 0.
- areset asserted for 1 cycle with 3 reads outstanding → all outputs 0 next cycle; outstanding = 0; beats returned afterwards set err_unexpected; arbitration restarts at requester 0.

Source files
------------

// File: rtl/gnn_buffer_read_arbiter.sv
// Round-robin arbiter sharing one in-order feature-buffer read port between requesters,
// with bounded burst hold and an ID FIFO that routes returned beats to their issuer.
module gnn_buffer_read_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned ADDR_WIDTH    = 11,
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned ID_FIFO_DEPTH = 8,
    parameter int unsigned MAX_HOLD      = 16
) (
    input  logic                                aclk,
    input  logic                                areset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_data,
    output logic                                buf_addr_valid,
    output logic [ADDR_WIDTH-1:0]               buf_addr,
    input  logic                                buf_data_valid,
    input  logic [DATA_WIDTH-1:0]               buf_data,
    output logic [$clog2(ID_FIFO_DEPTH):0]      outstanding,
    output logic                                err_unexpected
);

    localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned PTR_W  = (ID_FIFO_DEPTH > 1) ? $clog2(ID_FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(ID_FIFO_DEPTH) + 1;
    localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

    logic [ID_W-1:0]   last_id;
    logic [HOLD_W-1:0] hold_cnt;
    logic [ID_W-1:0]   id_mem [ID_FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [ID_W-1:0]    start_id;
    logic [ID_W-1:0]    cand;
    logic [ID_W-1:0]    grant_id;
    logic               grant_any;
    logic               keep;
    logic               stalled;
    logic               push;
    logic               pop;
    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] head_onehot;

    // Arbitration: keep the last winner while under its hold budget, else scan round-robin.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = last_id;
        cand      = '0;
        grant     = '0;
        stalled   = (count == CNT_W'(ID_FIFO_DEPTH)) && !buf_data_valid;
        keep      = (hold_cnt != '0) && (hold_cnt < HOLD_W'(MAX_HOLD)) && req_valid[last_id];
        start_id  = (last_id == ID_W'(NUM_REQ - 1)) ? '0 : last_id + ID_W'(1);
        if (!areset && !stalled) begin
            if (keep) begin
                grant_any = 1'b1;
                grant_id  = last_id;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    cand = ID_W'((32'(start_id) + 32'(k)) % NUM_REQ);
                    if (!grant_any && req_valid[cand]) begin
                        grant_any = 1'b1;
                        grant_id  = cand;
                    end
                end
            end
        end
        if (grant_any) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready   = grant;
    assign push        = grant_any;
    assign pop         = buf_data_valid && (count != '0);
    assign outstanding = count;

    always_comb begin
        head_onehot = '0;
        head_onehot[id_mem[rd_ptr]] = 1'b1;
    end

    // ID storage needs no reset: entries are only read while counted as valid.
    always_ff @(posedge aclk) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            last_id        <= ID_W'(NUM_REQ - 1);
            hold_cnt       <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            buf_addr_valid <= 1'b0;
            buf_addr       <= '0;
            rsp_valid      <= '0;
            rsp_data       <= '0;
            err_unexpected <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if ((grant_id == last_id) && (hold_cnt != '0)) begin
                    if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end else begin
                    last_id  <= grant_id;
                    hold_cnt <= HOLD_W'(1);
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);

            buf_addr_valid <= push;
            if (push) begin
                buf_addr <= req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            end

            rsp_valid <= pop ? head_onehot : '0;
            if (pop) begin
                rsp_data <= buf_data;
            end
            if (buf_data_valid && (count == '0)) begin
                err_unexpected <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gnn_buffer_read_arbiter.sv
// Randomized and directed bench for gnn_buffer_read_arbiter against a queue-based reference model.
module tb_gnn_buffer_read_arbiter;

    localparam int NR    = 2;
    localparam int AW    = 11;
    localparam int DW    = 512;
    localparam int DEPTH = 8;
    localparam int MH    = 4;

    logic              aclk;
    logic              areset;
    logic [NR-1:0]     req_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              buf_addr_valid;
    logic [AW-1:0]     buf_addr;
    logic              buf_data_valid;
    logic [DW-1:0]     buf_data;
    logic [3:0]        outstanding;
    logic              err_unexpected;

    gnn_buffer_read_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_FIFO_DEPTH(DEPTH), .MAX_HOLD(MH)
    ) dut (
        .aclk(aclk), .areset(areset), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .buf_addr_valid(buf_addr_valid), .buf_addr(buf_addr), .buf_data_valid(buf_data_valid),
        .buf_data(buf_data), .outstanding(outstanding), .err_unexpected(err_unexpected)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input logic [AW-1:0] a);
        return {16{5'b0, a, 16'hA5C3 ^ {5'b0, a}}};
    endfunction

    // stimulus controls
    logic [NR-1:0]    rv;
    logic [NR*AW-1:0] ra;
    logic             rst;
    logic             withhold;
    logic             spur;
    int               fixed_lat;
    logic             rand_lat;

    // buffer model: addresses in flight with their earliest return cycle
    logic [AW-1:0] pend_a[$];
    int            pend_t[$];
    int            cyc;

    // reference model state
    int            m_last;
    int            m_hold;
    int            idq[$];
    logic          m_err;
    logic          exp_bav;
    logic [AW-1:0] exp_baddr;
    logic [NR-1:0] exp_rsp_v;
    logic [DW-1:0] exp_rsp_d;

    logic [NR-1:0] last_ready;
    int            n_grant;
    int            peak;

    task automatic model_clear();
        m_last = -1;
        m_hold = 0;
        idq.delete();
        m_err = 1'b0;
        exp_bav = 1'b0;
        exp_baddr = '0;
        exp_rsp_v = '0;
        exp_rsp_d = '0;
    endtask

    task automatic step();
        logic          bdv;
        logic [DW-1:0] bdata;
        logic [NR-1:0] exp_ready;
        int            g;
        int            start;
        int            lat;
        bdv = 1'b0;
        bdata = '0;
        if (spur) begin
            bdv = 1'b1;
            bdata = mk_data(AW'($urandom));
        end else if (!withhold && pend_a.size() > 0 && pend_t[0] <= cyc) begin
            bdv = 1'b1;
            bdata = mk_data(pend_a.pop_front());
            void'(pend_t.pop_front());
        end
        areset = rst;
        req_valid = rv;
        req_addr = ra;
        buf_data_valid = bdv;
        buf_data = bdata;
        #1;
        g = -1;
        if (!rst && !(idq.size() == DEPTH && !bdv)) begin
            if (m_last >= 0 && rv[m_last] && m_hold < MH) begin
                g = m_last;
            end else begin
                start = (m_last + 1) % NR;
                for (int k = 0; k < NR; k++)
                    if (g < 0 && rv[(start + k) % NR]) g = (start + k) % NR;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", DW'(req_ready), DW'(exp_ready));
        last_ready = req_ready;
        if (req_ready != '0) n_grant++;
        if (rst) begin
            model_clear();
        end else begin
            exp_rsp_v = '0;
            if (bdv) begin
                if (idq.size() > 0) begin
                    exp_rsp_v[idq.pop_front()] = 1'b1;
                    exp_rsp_d = bdata;
                end else begin
                    m_err = 1'b1;
                end
            end
            exp_bav = 1'b0;
            if (g >= 0) begin
                idq.push_back(g);
                exp_bav = 1'b1;
                exp_baddr = ra[g*AW +: AW];
                lat = rand_lat ? int'($urandom_range(1, 4)) : fixed_lat;
                pend_a.push_back(exp_baddr);
                pend_t.push_back(cyc + 1 + lat);
                if (g == m_last) m_hold = (m_hold < MH) ? m_hold + 1 : MH;
                else begin
                    m_last = g;
                    m_hold = 1;
                end
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
        check("buf_addr_valid", DW'(buf_addr_valid), DW'(exp_bav));
        check("buf_addr", DW'(buf_addr), DW'(exp_baddr));
        check("rsp_valid", DW'(rsp_valid), DW'(exp_rsp_v));
        check("rsp_data", rsp_data, exp_rsp_d);
        check("outstanding", DW'(outstanding), DW'(idq.size()));
        check("err_unexpected", DW'(err_unexpected), DW'(m_err));
        if (int'(outstanding) > peak) peak = int'(outstanding);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic idle(input int n);
        rv = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        rv = '0; ra = '0; rst = 1'b1; withhold = 1'b0; spur = 1'b0;
        fixed_lat = 2; rand_lat = 1'b0; cyc = 0; n_grant = 0; peak = 0;
        last_ready = '0;
        model_clear();
        areset = 1'b1; req_valid = '0; req_addr = '0; buf_data_valid = 1'b0; buf_data = '0;
        @(posedge aclk);
        #1;
        do_reset();
        do_reset();
        check("reset_outstanding", DW'(outstanding), DW'(0));

        // single requester streams 16 addresses with latency 2
        n_grant = 0; peak = 0;
        for (int i = 0; i < 16; i++) begin
            rv = 2'b01;
            ra = {11'h000, 11'(16 + i)};
            step();
        end
        check("stream_grants", DW'(n_grant), DW'(16));
        idle(6);
        check("stream_peak", DW'(peak), DW'(3));

        // both requesters valid: runs of MAX_HOLD grants
        do_reset();
        rand_lat = 1'b1;
        for (int j = 0; j < 16; j++) begin
            rv = 2'b11;
            ra = NR*AW'($urandom);
            step();
            check("hold_pattern", DW'(last_ready), DW'(2'b01 << ((j / MH) % 2)));
        end
        idle(8);

        // withheld data: FIFO fills then a single returning beat frees a same-cycle slot
        do_reset();
        rand_lat = 1'b0; fixed_lat = 1; withhold = 1'b1; n_grant = 0;
        for (int i = 0; i < 10; i++) begin
            rv = 2'b10;
            ra = NR*AW'($urandom);
            step();
        end
        check("stall_grants", DW'(n_grant), DW'(8));
        check("stall_outstanding", DW'(outstanding), DW'(8));
        withhold = 1'b0;
        step();
        check("pop_push_grant", DW'(last_ready), DW'(2'b10));
        withhold = 1'b1;
        idle(1);
        check("pop_push_outstanding", DW'(outstanding), DW'(8));
        withhold = 1'b0;
        idle(12);

        // simultaneous rise: requester 0 first, then 1 once 0 drops
        do_reset();
        rv = 2'b11; ra = NR*AW'($urandom);
        step();
        check("first_grant", DW'(last_ready), DW'(2'b01));
        rv = 2'b10;
        step();
        check("switch_grant", DW'(last_ready), DW'(2'b10));
        idle(6);

        // spurious beat with nothing outstanding
        do_reset();
        spur = 1'b1;
        idle(1);
        spur = 1'b0;
        idle(3);
        check("err_sticky", DW'(err_unexpected), DW'(1));
        check("err_rsp_valid", DW'(rsp_valid), DW'(0));

        // reset with three reads in flight
        do_reset();
        withhold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rv = 2'b01;
            ra = NR*AW'($urandom);
            step();
        end
        check("pre_reset_outstanding", DW'(outstanding), DW'(3));
        do_reset();
        check("post_reset_outstanding", DW'(outstanding), DW'(0));
        check("post_reset_bav", DW'(buf_addr_valid), DW'(0));
        withhold = 1'b0;
        idle(6);
        check("stale_beat_err", DW'(err_unexpected), DW'(1));
        rv = 2'b11; ra = NR*AW'($urandom);
        step();
        check("restart_grant", DW'(last_ready), DW'(2'b01));
        idle(6);

        // randomized traffic
        rand_lat = 1'b1;
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            rv = NR'($urandom);
            if ($urandom_range(0, 3) == 0) rv = 2'b11;
            ra = NR*AW'($urandom);
            withhold = ($urandom_range(0, 3) == 0);
            spur = (pend_a.size() == 0) && ($urandom_range(0, 49) == 0);
            step();
        end
        rst = 1'b0; spur = 1'b0; withhold = 1'b0;
        idle(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
